// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the register-file write arbiter: pipeline writeback,
// late-result handshake, decode pending-check and the registered write port.
interface wb_write_arbiter_if;
    logic        i_wb_we;
    logic [4:0]  i_wb_waddr;
    logic [31:0] i_wb_wdata;

    logic        i_late_valid;
    logic        o_late_ready;
    logic [4:0]  i_late_waddr;
    logic [31:0] i_late_wdata;

    logic [4:0]  i_raddr1;
    logic [4:0]  i_raddr2;
    logic        o_busy1;
    logic        o_busy2;

    logic        o_stall_req;

    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    // Upstream side: pipeline, multi-cycle units and decode.
    modport master (
        output i_wb_we, i_wb_waddr, i_wb_wdata,
        output i_late_valid, i_late_waddr, i_late_wdata,
        output i_raddr1, i_raddr2,
        input  o_late_ready, o_busy1, o_busy2, o_stall_req,
        input  o_we, o_waddr, o_wdata
    );

    // Arbiter side.
    modport slave (
        input  i_wb_we, i_wb_waddr, i_wb_wdata,
        input  i_late_valid, i_late_waddr, i_late_wdata,
        input  i_raddr1, i_raddr2,
        output o_late_ready, o_busy1, o_busy2, o_stall_req,
        output o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Write-side front end of the 32x32 register file. The in-order pipeline
// writeback always wins the single write port; late results from multi-cycle
// units wait in a small FIFO and drain on cycles the pipeline leaves idle.
//
// Stall FSM:
//   state    | meaning
//   ST_RUN   | FIFO draining normally, no bubble requested
//   ST_STALL | FIFO starved or full with a result waiting; bubble requested
//              until the next pop
module wb_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wb_write_arbiter_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    wait_cnt;

    stall_state_t     state_q;
    stall_state_t     state_d;

    logic             wb_active;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             busy1;
    logic             busy2;

    assign wb_active  = bus.i_wb_we && (bus.i_wb_waddr != 5'd0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);

    // Ready is a pure function of occupancy so producers can drive valid
    // off it without a combinational loop.
    assign accept = bus.i_late_valid && !fifo_full;
    // r0 results complete the handshake but never occupy a slot.
    assign push   = accept && (bus.i_late_waddr != 5'd0);
    assign pop    = !wb_active && !fifo_empty;

    assign head_valid = q_valid[rd_ptr];

    assign bus.o_late_ready = !fifo_full;

    // Pending-destination lookup over live entries for the decode interlock.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i] == bus.i_raddr1)) busy1 = 1'b1;
            if (q_valid[i] && (q_addr[i] == bus.i_raddr2)) busy2 = 1'b1;
        end
    end

    assign bus.o_busy1 = busy1 && (bus.i_raddr1 != 5'd0);
    assign bus.o_busy2 = busy2 && (bus.i_raddr2 != 5'd0);

    // Pointers and occupancy; a full FIFO can pop and cannot push in the same
    // cycle because ready is taken from the pre-edge full flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry valid bits: a pipeline write kills older queued writes to the
    // same register so stale data never lands after the newer value. The
    // push slot is always free, so a same-cycle enqueue survives the kill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_active && q_valid[i] && (q_addr[i] == bus.i_wb_waddr))
                    q_valid[i] <= 1'b0;
            end
            if (pop)  q_valid[rd_ptr] <= 1'b0;
            if (push) q_valid[wr_ptr] <= 1'b1;
        end
    end

    // Entry payload storage; contents are only meaningful under q_valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.i_late_waddr;
            q_data[wr_ptr] <= bus.i_late_wdata;
        end
    end

    // Registered write port: pipeline first, else FIFO head, else idle hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_we    <= 1'b0;
            bus.o_waddr <= 5'd0;
            bus.o_wdata <= 32'd0;
        end else if (wb_active) begin
            bus.o_we    <= 1'b1;
            bus.o_waddr <= bus.i_wb_waddr;
            bus.o_wdata <= bus.i_wb_wdata;
        end else if (pop) begin
            bus.o_we <= head_valid;
            if (head_valid) begin
                bus.o_waddr <= q_addr[rd_ptr];
                bus.o_wdata <= q_data[rd_ptr];
            end
        end else begin
            bus.o_we <= 1'b0;
        end
    end

    // Undrained-cycle counter, saturating at the threshold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (pop || fifo_empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Stall state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Stall next-state: enter on starvation or a blocked producer, leave on pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!pop && ((wait_cnt >= WW'(MAX_WAIT)) ||
                             (fifo_full && bus.i_late_valid)))
                    state_d = ST_STALL;
            end
            ST_STALL: begin
                if (pop) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.o_stall_req = (state_q == ST_STALL);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter against a queue-based model.
module tb_wb_write_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic clk;
    logic rst;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_stall;
    int          m_wait;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit model_busy(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr == ra) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_stall = 1'b0;
        m_wait  = 0;
    endtask

    task automatic set_in(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                          input bit lv, input logic [4:0] la, input logic [31:0] ld,
                          input logic [4:0] r1, input logic [4:0] r2);
        bus.i_wb_we      = we;
        bus.i_wb_waddr   = wa;
        bus.i_wb_wdata   = wd;
        bus.i_late_valid = lv;
        bus.i_late_waddr = la;
        bus.i_late_wdata = ld;
        bus.i_raddr1     = r1;
        bus.i_raddr2     = r2;
    endtask

    task automatic check_outputs();
        check_val("late_ready", {31'd0, bus.o_late_ready}, {31'd0, (mq.size() < DEPTH)});
        check_val("busy1", {31'd0, bus.o_busy1}, {31'd0, model_busy(bus.i_raddr1)});
        check_val("busy2", {31'd0, bus.o_busy2}, {31'd0, model_busy(bus.i_raddr2)});
        check_val("stall_req", {31'd0, bus.o_stall_req}, {31'd0, m_stall});
        check_val("we", {31'd0, bus.o_we}, {31'd0, m_we});
        if (m_we) begin
            check_val("waddr", {27'd0, bus.o_waddr}, {27'd0, m_waddr});
            check_val("wdata", bus.o_wdata, m_wdata);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit active, full, pop, push;
        ent_t e;
        active = bus.i_wb_we && (bus.i_wb_waddr != 5'd0);
        full   = (mq.size() == DEPTH);
        push   = bus.i_late_valid && !full && (bus.i_late_waddr != 5'd0);
        pop    = !active && (mq.size() != 0);

        if (pop)
            m_stall = 1'b0;
        else if (m_wait >= MAX_WAIT || (full && bus.i_late_valid))
            m_stall = 1'b1;
        if (pop || mq.size() == 0) m_wait = 0;
        else                       m_wait++;

        if (active) begin
            m_we    = 1'b1;
            m_waddr = bus.i_wb_waddr;
            m_wdata = bus.i_wb_wdata;
            foreach (mq[i]) if (mq[i].addr == bus.i_wb_waddr) mq[i].live = 1'b0;
        end else if (pop) begin
            e    = mq.pop_front();
            m_we = e.live;
            if (e.live) begin
                m_waddr = e.addr;
                m_wdata = e.data;
            end
        end else begin
            m_we = 1'b0;
        end

        if (push) begin
            e.addr = bus.i_late_waddr;
            e.data = bus.i_late_wdata;
            e.live = 1'b1;
            mq.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 5'($urandom_range(0, 31)), $urandom, 1'b0, 5'd0, 32'd0, 5'd6, 5'd9);
            cycle();
        end
    endtask

    initial begin
        int k;
        int pw;
        int pl;
        bit can_push;

        model_reset();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        rst = 1'b1;
        #2;
        check_val("rst_we", {31'd0, bus.o_we}, 32'd0);
        check_val("rst_waddr", {27'd0, bus.o_waddr}, 32'd0);
        check_val("rst_wdata", bus.o_wdata, 32'd0);
        check_val("rst_stall", {31'd0, bus.o_stall_req}, 32'd0);
        check_val("rst_ready", {31'd0, bus.o_late_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Priority: pipeline r5 and late r6 in the same cycle.
        set_in(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'h22222222, 5'd6, 5'd5);
        cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
        cycle();
        idle(2);

        // r0: pipeline write to r0 still lets the FIFO drain; late r0 is dropped.
        set_in(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0);
        cycle();
        set_in(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd7);
        cycle();
        idle(3);

        // WAW kill.
        set_in(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd9, 32'hDEAD0001, 5'd9, 5'd0);
        cycle();
        set_in(1'b1, 5'd9, 32'hBEEF0002, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        cycle();
        idle(3);

        // Full FIFO with wrap-around over 10 pushes.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            can_push = (mq.size() < DEPTH);
            set_in((c < 8) || (c % 2 == 0), 5'd1, $urandom,
                   (k < 10), 5'(10 + k), $urandom, 5'(10 + k), 5'd10);
            cycle();
            if (can_push && k < 10) k++;
        end
        idle(4);

        // Starvation: one entry held back by a continuously active pipeline.
        set_in(1'b1, 5'd1, $urandom, 1'b1, 5'd20, 32'h20202020, 5'd20, 5'd0);
        cycle();
        for (int c = 0; c < 20; c++) begin
            set_in(1'b1, 5'd2, $urandom, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
            cycle();
        end
        idle(3);

        // Asynchronous reset mid-stream with three entries queued.
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 5'd8, $urandom, 1'b1, 5'(1 + c), $urandom, 5'd1, 5'd2);
            cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_we", {31'd0, bus.o_we}, 32'd0);
        check_val("mid_rst_busy1", {31'd0, bus.o_busy1}, 32'd0);
        check_val("mid_rst_busy2", {31'd0, bus.o_busy2}, 32'd0);
        check_val("mid_rst_ready", {31'd0, bus.o_late_ready}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        for (int c = 0; c < 4; c++) cycle();

        // Randomized phases with varying pipeline / late-result densities.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pw = 90; pl = 80; end
                1:       begin pw = 50; pl = 50; end
                2:       begin pw = 20; pl = 60; end
                default: begin pw = 70; pl = 30; end
            endcase
            for (int c = 0; c < 100; c++) begin
                set_in($urandom_range(0, 99) < pw, 5'($urandom_range(0, 7)), $urandom,
                       $urandom_range(0, 99) < pl, 5'($urandom_range(0, 7)), $urandom,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                cycle();
            end
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
